// File: rtl/multicycle_ctrl_if.sv
// multicycle_ctrl_if: sequencer-to-datapath strobe bundle with memory handshake
interface multicycle_ctrl_if;
    logic [6:0]  opcode;
    logic        mem_ready;
    logic        zero;
    logic        stall;
    logic        pc_write;
    logic        pc_src;
    logic        ir_write;
    logic        mem_req;
    logic        mem_we;
    logic [2:0]  alu_op;
    logic        alu_src;
    logic        reg_write;
    logic        mem_to_reg;
    logic        illegal;
    logic        timeout;
    logic [31:0] instret;
    modport master (
        input  opcode, mem_ready, zero, stall,
        output pc_write, pc_src, ir_write, mem_req, mem_we, alu_op, alu_src,
               reg_write, mem_to_reg, illegal, timeout, instret
    );
    modport slave (
        output opcode, mem_ready, zero, stall,
        input  pc_write, pc_src, ir_write, mem_req, mem_we, alu_op, alu_src,
               reg_write, mem_to_reg, illegal, timeout, instret
    );
endinterface

// File: rtl/multicycle_ctrl.sv
// multicycle_ctrl: RV32I multi-cycle sequencer; PERF_CNT_EN builds the retired-instruction counter
module multicycle_ctrl #(
    parameter int MEM_TIMEOUT = 16
) (
    input logic clk,
    input logic rst,
    multicycle_ctrl_if.master bus
);
    localparam logic [2:0] FETCH = 3'd0, DECODE = 3'd1, EXEC = 3'd2, MEM = 3'd3, WB = 3'd4, TRAP = 3'd5;
    localparam logic [2:0] C_NONE = 3'd0, C_BR = 3'd1, C_ST = 3'd2, C_R = 3'd3, C_LD = 3'd4, C_IMM = 3'd5, C_U = 3'd6, C_J = 3'd7;
    logic [2:0] state, state_next, cls, dec_cls;
    logic [7:0] cnt;
    logic       illegal_q, timeout_q, hold, expired, mem_req_i, post;
    assign mem_req_i = state == FETCH || state == MEM;
    assign hold      = bus.stall && (state == DECODE || state == EXEC || state == WB);
    assign expired   = mem_req_i && !bus.mem_ready && cnt == 8'(MEM_TIMEOUT - 1);
    assign post      = state == EXEC || state == MEM || state == WB;
    // opcode to instruction class; NONE marks an unsupported opcode
    always_comb begin
        dec_cls = C_NONE;
        case (bus.opcode)
            7'b1100011: dec_cls = C_BR;
            7'b0100011: dec_cls = C_ST;
            7'b0110011: dec_cls = C_R;
            7'b0000011: dec_cls = C_LD;
            7'b0001111, 7'b0010011, 7'b1100111, 7'b1110011: dec_cls = C_IMM;
            7'b0010111, 7'b0110111: dec_cls = C_U;
            7'b1101111: dec_cls = C_J;
            default: dec_cls = C_NONE;
        endcase
    end
    // next state: a memory timeout overrides everything, stall freezes the non-memory states
    always_comb begin
        state_next = state;
        if (expired)
            state_next = TRAP;
        else if (!hold)
            case (state)
                FETCH:   state_next = bus.mem_ready ? DECODE : FETCH;
                DECODE:  state_next = dec_cls == C_NONE ? TRAP : EXEC;
                EXEC:    state_next = cls == C_BR ? FETCH : (cls == C_LD || cls == C_ST) ? MEM : WB;
                MEM:     state_next = !bus.mem_ready ? MEM : cls == C_ST ? FETCH : WB;
                WB:      state_next = FETCH;
                default: state_next = state;
            endcase
    end
    // state, latched class, handshake wait counter and sticky error flags
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= FETCH;
            cls       <= C_NONE;
            cnt       <= '0;
            illegal_q <= 1'b0;
            timeout_q <= 1'b0;
        end else begin
            state <= state_next;
            if (state == DECODE)
                cls <= dec_cls;
            cnt <= (state_next != state || bus.mem_ready) ? 8'd0 : cnt + 8'(mem_req_i);
            if (state == DECODE && !hold && dec_cls == C_NONE)
                illegal_q <= 1'b1;
            if (expired)
                timeout_q <= 1'b1;
        end
    end
`ifdef PERF_CNT_EN
    logic        retire;
    logic [31:0] instret_q;
    assign retire = !expired && !hold &&
                    ((state == EXEC && cls == C_BR) ||
                     (state == MEM && cls == C_ST && bus.mem_ready) ||
                     state == WB);
    // retired-instruction count, wraps naturally
    always_ff @(posedge clk) begin
        if (rst)
            instret_q <= '0;
        else if (retire)
            instret_q <= instret_q + 32'd1;
    end
    assign bus.instret = rst ? 32'd0 : instret_q;
`else
    assign bus.instret = 32'd0;
`endif
    assign bus.mem_req    = !rst && mem_req_i;
    assign bus.mem_we     = !rst && state == MEM && cls == C_ST;
    assign bus.ir_write   = !rst && state == FETCH && bus.mem_ready;
    assign bus.pc_write   = !rst && ((state == FETCH && bus.mem_ready) ||
                            (state == EXEC && !bus.stall && (cls == C_J || (cls == C_BR && bus.zero))));
    assign bus.pc_src     = !rst && state == EXEC && (cls == C_BR || cls == C_J);
    assign bus.alu_op     = (rst || !post) ? 3'b000 : cls == C_BR ? 3'b001 : cls == C_R ? 3'b010 :
                            cls == C_IMM ? 3'b011 : cls == C_U ? 3'b100 : 3'b000;
    assign bus.alu_src    = !rst && post && (cls == C_ST || cls == C_LD || cls == C_IMM || cls == C_U);
    assign bus.reg_write  = !rst && state == WB && !bus.stall;
    assign bus.mem_to_reg = !rst && state == WB && cls == C_LD;
    assign bus.illegal    = !rst && illegal_q;
    assign bus.timeout    = !rst && timeout_q;
endmodule
